// File: rtl/pronoc_pkg.sv
// Shared parameters, channel/flit typedefs and payload slice helpers for the
// endpoint packet injector.
package pronoc_pkg;
  localparam int NE       = 16;
  localparam int EAw      = 4;
  localparam int DSTPw    = 16;
  localparam int MCAST    = 1;
  localparam int V        = 2;
  localparam int B        = 4;
  localparam int Fpay     = 64;
  localparam int DATAw    = 128;
  localparam int PCK_SIZw = 5;
  localparam int C        = 2;
  localparam int Cw       = (C > 2) ? $clog2(C) : 1;
  localparam int WEIGHTw  = 4;
  localparam int Fw       = 2 + V + Fpay;
  localparam int CRDw     = $clog2(B + 1);
  localparam int NSLICE   = (DATAw + Fpay - 1) / Fpay;
  localparam int EXTw     = NSLICE * Fpay;

  typedef struct packed {
    logic            hdr_flg;
    logic            tail_flg;
    logic [V-1:0]    vc;
    logic [Fpay-1:0] payload;
  } flit_t;

  typedef struct packed {
    logic         flit_wr;
    flit_t        flit;
    logic [V-1:0] credit;
  } smartflit_chanel_t;

  typedef struct packed {
    logic [DATAw-1:0]    data;
    logic [PCK_SIZw-1:0] size;
    logic [DSTPw-1:0]    endp_addr;
    logic [Cw-1:0]       class_num;
    logic [WEIGHTw-1:0]  init_weight;
    logic [V-1:0]        vc;
    logic                pck_wr;
    logic [V-1:0]        ready;
  } pck_injct_t;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_HDR,
    TX_BODY,
    TX_TAIL
  } tx_state_t;

  // Payload of flit k (k>=1); slices past the end of the data read as zero.
  function automatic logic [Fpay-1:0] data_slice(input logic [DATAw-1:0] d,
                                                 input logic [PCK_SIZw-1:0] k);
    logic [EXTw-1:0] ext;
    logic [Fpay-1:0] r;
    ext = EXTw'(d);
    r   = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (k == PCK_SIZw'(s + 1)) r = ext[s*Fpay +: Fpay];
    end
    return r;
  endfunction

  // Writes payload into 0-based slot idx; out-of-range slots are dropped.
  function automatic logic [DATAw-1:0] put_slice(input logic [DATAw-1:0] d,
                                                 input logic [PCK_SIZw-1:0] idx,
                                                 input logic [Fpay-1:0] p);
    logic [EXTw-1:0] ext;
    ext = EXTw'(d);
    for (int s = 0; s < NSLICE; s++) begin
      if (idx == PCK_SIZw'(s)) ext[s*Fpay +: Fpay] = p;
    end
    return DATAw'(ext);
  endfunction
endpackage

// File: rtl/injector_credit_counter.sv
// Per-VC downstream credit counter: starts full at B, saturates at B, holds
// when a send and a returned credit land in the same cycle.
module injector_credit_counter
  import pronoc_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic dec,
  output logic nz
);
  logic [CRDw-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= CRDw'(B);
    end else if (inc && !dec && cnt != CRDw'(B)) begin
      cnt <= cnt + CRDw'(1);
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - CRDw'(1);
    end
  end

  assign nz = (cnt != '0);
endmodule

// File: rtl/multicast_pck_injector.sv
// Endpoint injector/ejector: serializes packet commands into header/body/tail
// flits under per-VC credits and reassembles incoming flits per VC.
module multicast_pck_injector
  import pronoc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [EAw-1:0]    current_e_addr,
  output smartflit_chanel_t chan_out,
  input  smartflit_chanel_t chan_in,
  input  pck_injct_t        pck_injct_in,
  output pck_injct_t        pck_injct_out
);
  tx_state_t           state_q, state_d;
  logic [V-1:0]        crd_nz, ready, crd_dec, vc_q;
  logic [DSTPw-1:0]    dst_q;
  logic [PCK_SIZw-1:0] size_q, idx_q, idx_d;
  logic [DATAw-1:0]    data_q;
  logic [Cw-1:0]       cls_q;
  logic [WEIGHTw-1:0]  wgt_q;
  logic                accept, crd_ok, send;
  flit_t               tx_flit;

  logic [V-1:0][EAw-1:0]      rx_src;
  logic [V-1:0][Cw-1:0]       rx_cls;
  logic [V-1:0][PCK_SIZw-1:0] rx_cnt;
  logic [V-1:0][DATAw-1:0]    rx_data;
  logic [V-1:0]               crd_out_q;
  logic                       out_pck_wr;
  logic [EAw-1:0]             out_src;
  logic [PCK_SIZw-1:0]        out_size;
  logic [DATAw-1:0]           out_data;
  logic [Cw-1:0]              out_cls;
  logic                       unused_in;

  assign unused_in = ^pck_injct_in.ready;

  // Ready is forced low while reset is held even though credits read full.
  assign ready   = (state_q == TX_IDLE && reset) ? crd_nz : '0;
  assign accept  = pck_injct_in.pck_wr & (|(pck_injct_in.vc & ready));
  assign crd_ok  = |(vc_q & crd_nz);
  assign crd_dec = send ? vc_q : '0;

  for (genvar v = 0; v < V; v++) begin : g_crd
    injector_credit_counter u_crd (
      .clk   (clk),
      .reset (reset),
      .inc   (chan_in.credit[v]),
      .dec   (crd_dec[v]),
      .nz    (crd_nz[v])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dst_q  <= '0;
      size_q <= '0;
      data_q <= '0;
      cls_q  <= '0;
      wgt_q  <= '0;
      vc_q   <= '0;
    end else if (accept) begin
      dst_q  <= pck_injct_in.endp_addr;
      size_q <= (pck_injct_in.size < PCK_SIZw'(2)) ? PCK_SIZw'(2) : pck_injct_in.size;
      data_q <= pck_injct_in.data;
      cls_q  <= pck_injct_in.class_num;
      wgt_q  <= pck_injct_in.init_weight;
      vc_q   <= pck_injct_in.vc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    send    = 1'b0;
    tx_flit = '0;
    case (state_q)
      TX_IDLE: begin
        if (accept) begin
          state_d = TX_HDR;
          idx_d   = '0;
        end
      end
      TX_HDR: begin
        if (crd_ok) begin
          send             = 1'b1;
          tx_flit.hdr_flg  = 1'b1;
          tx_flit.payload  = Fpay'({wgt_q, cls_q, dst_q, current_e_addr});
          idx_d            = PCK_SIZw'(1);
          state_d          = (size_q == PCK_SIZw'(2)) ? TX_TAIL : TX_BODY;
        end
      end
      TX_BODY: begin
        if (crd_ok) begin
          send            = 1'b1;
          tx_flit.payload = data_slice(data_q, idx_q);
          idx_d           = idx_q + PCK_SIZw'(1);
          if (idx_q == size_q - PCK_SIZw'(2)) state_d = TX_TAIL;
        end
      end
      TX_TAIL: begin
        if (crd_ok) begin
          send             = 1'b1;
          tx_flit.tail_flg = 1'b1;
          tx_flit.payload  = data_slice(data_q, idx_q);
          state_d          = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
    if (send) tx_flit.vc = vc_q;
  end

  // Receive side: every flit is consumed and credited back the next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_src     <= '0;
      rx_cls     <= '0;
      rx_cnt     <= '0;
      rx_data    <= '0;
      crd_out_q  <= '0;
      out_pck_wr <= 1'b0;
      out_src    <= '0;
      out_size   <= '0;
      out_data   <= '0;
      out_cls    <= '0;
    end else begin
      crd_out_q  <= chan_in.flit_wr ? chan_in.flit.vc : '0;
      out_pck_wr <= 1'b0;
      for (int v = 0; v < V; v++) begin
        if (chan_in.flit_wr && chan_in.flit.vc[v]) begin
          if (chan_in.flit.hdr_flg) begin
            rx_src[v]  <= chan_in.flit.payload[EAw-1:0];
            rx_cls[v]  <= chan_in.flit.payload[EAw+DSTPw +: Cw];
            rx_cnt[v]  <= PCK_SIZw'(1);
            rx_data[v] <= '0;
          end else begin
            rx_data[v] <= put_slice(rx_data[v], rx_cnt[v] - PCK_SIZw'(1), chan_in.flit.payload);
            rx_cnt[v]  <= rx_cnt[v] + PCK_SIZw'(1);
            if (chan_in.flit.tail_flg) begin
              out_pck_wr <= 1'b1;
              out_src    <= rx_src[v];
              out_size   <= rx_cnt[v] + PCK_SIZw'(1);
              out_data   <= put_slice(rx_data[v], rx_cnt[v] - PCK_SIZw'(1), chan_in.flit.payload);
              out_cls    <= rx_cls[v];
            end
          end
        end
      end
    end
  end

  always_comb begin
    chan_out         = '0;
    chan_out.flit_wr = send;
    chan_out.flit    = tx_flit;
    chan_out.credit  = crd_out_q;
  end

  always_comb begin
    pck_injct_out           = '0;
    pck_injct_out.ready     = ready;
    pck_injct_out.pck_wr    = out_pck_wr;
    pck_injct_out.endp_addr = DSTPw'(out_src);
    pck_injct_out.size      = out_size;
    pck_injct_out.data      = out_data;
    pck_injct_out.class_num = out_cls;
  end
endmodule

// File: tb/tb_multicast_pck_injector.sv
// Loopback bench: expected flits and packets are queued at command issue and
// popped by a monitor whenever the DUT presents a flit or a received packet.
module tb_multicast_pck_injector;
  import pronoc_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic [EAw-1:0]    cur_addr;
  smartflit_chanel_t chan_out, chan_in;
  pck_injct_t        inj_in, inj_out;
  logic              loop_crd;
  logic [V-1:0]      tb_credit;

  always #5 clk = ~clk;

  always_comb begin
    chan_in        = chan_out;
    chan_in.credit = loop_crd ? chan_out.credit : tb_credit;
  end

  multicast_pck_injector dut (
    .clk            (clk),
    .reset          (reset),
    .current_e_addr (cur_addr),
    .chan_out       (chan_out),
    .chan_in        (chan_in),
    .pck_injct_in   (inj_in),
    .pck_injct_out  (inj_out)
  );

  typedef struct packed {
    logic [EAw-1:0]      src;
    logic [PCK_SIZw-1:0] size;
    logic [DATAw-1:0]    data;
    logic [Cw-1:0]       cls;
  } rx_exp_t;

  flit_t   exp_flits[$];
  rx_exp_t exp_pcks[$];
  int      checks = 0;
  int      errors = 0;
  int      n_flits = 0;
  flit_t   mf;
  rx_exp_t mp, ap;

  always @(negedge clk) begin
    if (chan_out.flit_wr) begin
      n_flits++;
      checks++;
      if (exp_flits.size() == 0) begin
        errors++;
        $display("FAIL unexpected_flit actual=%h required=none", chan_out.flit);
      end else begin
        mf = exp_flits.pop_front();
        if (chan_out.flit !== mf) begin
          errors++;
          $display("FAIL flit actual=%h required=%h", chan_out.flit, mf);
        end
      end
    end
    if (inj_out.pck_wr) begin
      checks++;
      ap = '{src: inj_out.endp_addr[EAw-1:0], size: inj_out.size,
             data: inj_out.data, cls: inj_out.class_num};
      if (exp_pcks.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pck actual=%h required=none", ap);
      end else begin
        mp = exp_pcks.pop_front();
        if (ap !== mp) begin
          errors++;
          $display("FAIL rx_pck actual=%h required=%h", ap, mp);
        end
      end
    end
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_pkt(input logic [V-1:0] vc, input int sz, input logic [DATAw-1:0] d,
                          input logic [DSTPw-1:0] dst, input logic [Cw-1:0] cls,
                          input logic [WEIGHTw-1:0] w);
    int      n, t;
    flit_t   f;
    rx_exp_t p;
    t = 0;
    while (!(|(inj_out.ready & vc)) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=%b required=%b", inj_out.ready, vc);
      return;
    end
    n = (sz < 2) ? 2 : sz;
    for (int k = 0; k < n; k++) begin
      f          = '0;
      f.hdr_flg  = (k == 0);
      f.tail_flg = (k == n - 1);
      f.vc       = vc;
      if (k == 0) f.payload = Fpay'({w, cls, dst, cur_addr});
      else if (k - 1 < DATAw / Fpay) f.payload = d[(k-1)*Fpay +: Fpay];
      exp_flits.push_back(f);
    end
    p      = '0;
    p.src  = cur_addr;
    p.size = PCK_SIZw'(n);
    p.cls  = cls;
    for (int s = 0; s < n - 1 && s < DATAw / Fpay; s++) p.data[s*Fpay +: Fpay] = d[s*Fpay +: Fpay];
    exp_pcks.push_back(p);
    inj_in             = '0;
    inj_in.vc          = vc;
    inj_in.size        = PCK_SIZw'(sz);
    inj_in.data        = d;
    inj_in.endp_addr   = dst;
    inj_in.class_num   = cls;
    inj_in.init_weight = w;
    inj_in.pck_wr      = 1'b1;
    @(posedge clk); #1;
    inj_in.pck_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp_flits.size() != 0 || exp_pcks.size() != 0) && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (t >= 400) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout actual=%0d/%0d required=0/0", exp_flits.size(), exp_pcks.size());
      exp_flits.delete();
      exp_pcks.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  logic [DATAw-1:0] d0, d1, d2, d3;
  int base;

  initial begin
    d0 = 128'h123456789ABCDEFEDCBA987654321;
    d1 = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;
    d2 = 128'hFFFF_EEEE_DDDD_CCCC_0102_0304_0506_0708;
    d3 = 128'hCAFE_F00D_DEAD_BEEF_0BAD_C0DE_1234_5678;
    reset = 1'b1; cur_addr = '0; loop_crd = 1'b1; tb_credit = '0; inj_in = '0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clk); #1;
    check("ready_in_reset", inj_out.ready, 0);
    check("flit_wr_in_reset", chan_out.flit_wr, 0);
    check("pck_wr_in_reset", inj_out.pck_wr, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", inj_out.ready, 2'b11);
    check("flit_wr_after_reset", chan_out.flit_wr, 0);
    check("pck_wr_after_reset", inj_out.pck_wr, 0);
    check("credit_out_after_reset", chan_out.credit, 0);

    // Loopback, 3 flits, then clamped sizes on both VCs
    send_pkt(2'b01, 3, d0, 16'h0001, 1'b0, 4'h3);
    check("ready_busy", inj_out.ready, 2'b00);
    wait_idle();
    send_pkt(2'b10, 1, d1, 16'h8001, 1'b1, 4'hF);
    wait_idle();
    send_pkt(2'b01, 0, d3, 16'h0010, 1'b1, 4'h9);
    wait_idle();

    // Credit stall: no credit return after the first 4 flits
    loop_crd = 1'b0; tb_credit = '0;
    base = n_flits;
    send_pkt(2'b01, 6, d2, 16'h0100, 1'b1, 4'h5);
    repeat (10) @(posedge clk); #1;
    check("stall_flit_count", n_flits - base, 4);
    check("stall_flit_wr", chan_out.flit_wr, 0);
    check("stall_ready0", inj_out.ready[0], 0);
    tb_credit = 2'b01;
    @(posedge clk); #1;
    tb_credit = '0;
    check("resume1_ready0", inj_out.ready[0], 0);
    @(posedge clk); #1;
    check("resume1_count", n_flits - base, 5);
    tb_credit = 2'b01;
    @(posedge clk); #1;
    tb_credit = '0;
    check("resume2_ready0", inj_out.ready[0], 0);
    @(posedge clk); #1;
    check("resume2_count", n_flits - base, 6);
    check("after_tail_ready", inj_out.ready, 2'b10);
    wait_idle();
    tb_credit = 2'b11;
    repeat (6) @(posedge clk); #1;
    tb_credit = '0;
    loop_crd = 1'b1;
    check("credits_restored", inj_out.ready, 2'b11);

    // Command while busy is ignored
    send_pkt(2'b10, 5, d1, 16'h0004, 1'b0, 4'h2);
    check("busy_ready", inj_out.ready, 2'b00);
    inj_in = '0; inj_in.vc = 2'b10; inj_in.size = 5'd3; inj_in.data = d3; inj_in.pck_wr = 1'b1;
    @(posedge clk); #1;
    inj_in.vc = 2'b01;
    @(posedge clk); #1;
    inj_in.pck_wr = 1'b0;
    wait_idle();
    repeat (10) @(posedge clk); #1;

    // 20-flit packet from a different source address
    cur_addr = 4'h5;
    send_pkt(2'b01, 20, d0, 16'h0020, 1'b1, 4'hA);
    wait_idle();

    // Reset in the middle of a packet
    cur_addr = 4'h0;
    base = n_flits;
    send_pkt(2'b01, 8, d2, 16'h0001, 1'b0, 4'h1);
    for (int t = 0; t < 100 && n_flits < base + 3; t++) @(posedge clk);
    #2 reset = 1'b0;
    exp_flits.delete();
    exp_pcks.delete();
    #1;
    check("midrst_flit_wr", chan_out.flit_wr, 0);
    check("midrst_pck_wr", inj_out.pck_wr, 0);
    check("midrst_ready", inj_out.ready, 0);
    repeat (2) @(posedge clk); #1;
    reset = 1'b1;
    repeat (8) @(posedge clk); #1;
    check("postrst_ready", inj_out.ready, 2'b11);
    loop_crd = 1'b0; tb_credit = '0;
    base = n_flits;
    send_pkt(2'b01, 4, d3, 16'h0002, 1'b1, 4'h7);
    wait_idle();
    check("postrst_full_credit", n_flits - base, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicast_pck_injector.md
Name: multicast_pck_injector

Overview:
- Endpoint-side packet injector/ejector between a local packet-level control interface and one NoC router port.
- Injection: one packet command (destination, size, data, class, weight, VC) is serialized into a header/body/tail flit stream under per-VC credit flow control.
- Ejection: incoming flits are reassembled per VC, and one pck_wr pulse is reported per completed packet.
- One instance per endpoint, attached to noc_top chan_in_all/chan_out_all[i].

Parameters:
- NE, 16: endpoint count.
- EAw, 4: encoded endpoint address width.
- DSTPw, 16: destination field width. When MCAST=1 it is an NE-bit destination bitmap; otherwise it is an encoded address (low EAw bits).
- MCAST, 1: multicast enable. The field is only carried here; routers interpret it.
- V, 2: virtual channels per port.
- B, 4: flit buffer depth per VC in the downstream router, which equals the initial credits.
- Fpay, 64: flit payload width. Must satisfy Fpay >= EAw+DSTPw+Cw+WEIGHTw.
- DATAw, 128: packet data width.
- PCK_SIZw, 5: size field width, in flits.
- C, 2: message classes. Cw = max(1, log2 C).
- WEIGHTw, 4: init_weight width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- current_e_addr  in  EAw  this endpoint's encoded address.
- chan_out.flit_wr  out  1  flit valid toward router.
- chan_out.flit  out  2+V+Fpay  {hdr_flg, tail_flg, vc one-hot[V], payload[Fpay]}.
- chan_out.credit  out  V  one-cycle pulse per flit consumed from chan_in.
- chan_in.flit_wr / chan_in.flit / chan_in.credit  in  same widths  from router.
- pck_injct_in.pck_wr  in  1  packet command strobe.
- pck_injct_in.endp_addr  in  DSTPw  destination.
- pck_injct_in.size  in  PCK_SIZw  total flits.
- pck_injct_in.data  in  DATAw  packet data.
- pck_injct_in.class_num  in  Cw  message class.
- pck_injct_in.init_weight  in  WEIGHTw  initial weight.
- pck_injct_in.vc  in  V  one-hot VC select.
- pck_injct_out.ready  out  V  per-VC accept-ready.
- pck_injct_out.pck_wr  out  1  received-packet pulse.
- pck_injct_out.endp_addr  out  EAw  source of received packet.
- pck_injct_out.size  out  PCK_SIZw  received flit count.
- pck_injct_out.data  out  DATAw  received data.
- pck_injct_out.class_num  out  Cw  received class.

Behaviour:
- Reset (reset=0, asynchronous):
  - All outputs are 0.
  - credit[v] = B for every VC.
  - TX FSM = IDLE; all RX reassembly registers are cleared.
- ready[v] = (FSM==IDLE) & (credit[v]!=0) & reset deasserted.
- Command acceptance:
  - A command is taken when pck_wr=1 in the same cycle as ready[sel vc]=1.
  - On acceptance, dest, size, data, class, weight and vc are latched. size<2 is clamped to 2.
  - pck_wr while not ready is ignored, with no error flag.
- TX FSM:
  - IDLE -> HDR on acceptance.
  - HDR sends the header flit: hdr_flg=1; payload = {weight, class, dest, src=current_e_addr}, packed LSB-first, zero-padded.
  - BODY sends flits 1..size-2, then TAIL sends flit size-1 with tail_flg=1; TAIL -> IDLE.
  - Flit k (k>=1) payload = data[(k-1)*Fpay +: Fpay]. Bits beyond DATAw read as 0.
  - A flit is emitted (flit_wr=1) only in a cycle where credit[vc]!=0; otherwise the FSM stalls in its state with flit_wr=0.
  - Throughput is one flit per cycle. The first flit appears the cycle after acceptance.
- Credits:
  - On send: credit[vc] decrements.
  - On chan_in.credit[v]: credit[v] increments.
  - Both events in the same cycle: credit[v] is unchanged.
  - The counter saturates at B.
- RX:
  - Every incoming flit is consumed. The cycle after it arrives, chan_out.credit pulses on its vc.
  - Reassembly is per VC. A header clears that VC's registers and latches src and class, count=1.
  - Each body/tail flit stores its payload into data slice count-1 (slices beyond DATAw are dropped), then count++.
  - On the tail flit: pck_wr=1 for exactly one cycle, the cycle after the tail arrives. It carries endp_addr=src, size=count, data, class.
  - A header arriving mid-packet restarts that VC's reassembly.
  - A packet on one VC may interleave with a packet on another VC.
- Reset asserted mid-packet aborts TX and RX immediately. No partial pck_wr is produced.

Decomposition:
- pronoc_pkg holds:
  - NE, EAw, DSTPw, V, B, Fpay, DATAw, PCK_SIZw, C, WEIGHTw;
  - the flit and smartflit_chanel_t channel typedefs;
  - pck_injct_t {data, size, endp_addr, class_num, init_weight, vc, pck_wr, ready}, shared by both directions.
- One sub-module, injector_credit_counter, instantiated V times for the per-VC credit counters.
- The TX FSM and RX reassembly stay in the top module.

Test Plan:
- Reset then release, no traffic -> ready=all ones (V=2: 2'b11), flit_wr=0, pck_injct_out.pck_wr=0.
- Loopback on endpoint 0, vc=2'b01, size=3, data=0x123456789ABCDEFEDCBA987654321 -> 3 flits (hdr, body, tail); one pck_wr pulse with size=3, endp_addr=0, data[Fpay*2-1:0] identical to sent.
- Credits held at 0 after 4 flits (B=4), size=6 packet -> stall after the 4th flit; two credit pulses resume the last 2 flits; ready[0]=0 until the tail has been sent.
- pck_wr while busy -> command ignored; only the first packet appears at the receiver.
- Size 20 with DATAw=128 -> body slices beyond data read 0; receiver size=20, data equal to sent.
- Reset asserted mid-packet -> flit_wr=0 immediately, credits back to B, no pck_wr pulse.
